// File: rtl/alu_result_stage.sv
// alu_result_stage: captures ALU Y/OF/F, derives Z/N/V flags at push time,
// buffers entries in a DEPTH-deep FIFO and tracks overflow history.
//
// Handshake: a transfer happens on a rising edge only when valid and ready
// are both high on that side (push = in_valid && in_ready, pop = out_valid
// && out_ready). in_ready and out_valid are functions of registered
// occupancy only, so neither depends combinationally on the other side.
// The head entry is held stable while out_valid=1 and out_ready=0.
module alu_result_stage #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_y,
  input  logic                         in_of,
  input  logic [2:0]                   in_f,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_y,
  output logic [2:0]                   out_f,
  output logic                         out_z,
  output logic                         out_n,
  output logic                         out_v,
  input  logic                         clr_sticky,
  output logic                         sticky_of,
  output logic [7:0]                   of_count,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [WIDTH-1:0] y_mem [DEPTH];
  logic [2:0]       f_mem [DEPTH];
  logic [DEPTH-1:0] z_mem;
  logic [DEPTH-1:0] n_mem;
  logic [DEPTH-1:0] v_mem;

  logic push;
  logic pop;
  logic push_z;
  logic push_n;
  logic push_v;

  assign in_ready  = (count < FULL_CNT);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Flags are derived from the incoming result; only add (2) and sub (6)
  // can report a meaningful overflow, every other code gets v=0.
  assign push_z = (in_y == '0);
  assign push_n = in_y[WIDTH-1];
  assign push_v = in_of && ((in_f == 3'd2) || (in_f == 3'd6));

  // Head entry is presented only while valid, so outputs read 0 when empty
  // and immediately on reset (occupancy clears asynchronously).
  assign out_y = out_valid ? y_mem[rd_ptr] : '0;
  assign out_f = out_valid ? f_mem[rd_ptr] : 3'd0;
  assign out_z = out_valid && z_mem[rd_ptr];
  assign out_n = out_valid && n_mem[rd_ptr];
  assign out_v = out_valid && v_mem[rd_ptr];

  // Storage write: payload and flags land in the slot at the write pointer.
  always_ff @(posedge clk) begin
    if (push && reset_n) begin
      y_mem[wr_ptr]  <= in_y;
      f_mem[wr_ptr]  <= in_f;
      z_mem[wr_ptr]  <= push_z;
      n_mem[wr_ptr]  <= push_n;
      v_mem[wr_ptr]  <= push_v;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Overflow history: a v=1 push beats a coincident clear; the counter
  // saturates and ignores clr_sticky.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sticky_of <= 1'b0;
      of_count  <= 8'd0;
    end else begin
      if (push && push_v)  sticky_of <= 1'b1;
      else if (clr_sticky) sticky_of <= 1'b0;
      if (push && push_v && (of_count != 8'hFF)) of_count <= of_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed testbench for alu_result_stage: linear sequence of steps with
// hand-computed expected values checked by immediate assertions.
module tb_alu_result_stage;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_y;
  logic        in_of;
  logic [2:0]  in_f;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_y;
  logic [2:0]  out_f;
  logic        out_z;
  logic        out_n;
  logic        out_v;
  logic        clr_sticky;
  logic        sticky_of;
  logic [7:0]  of_count;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  alu_result_stage #(.WIDTH(32), .DEPTH(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_y       (in_y),
    .in_of      (in_of),
    .in_f       (in_f),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_y      (out_y),
    .out_f      (out_f),
    .out_z      (out_z),
    .out_n      (out_n),
    .out_v      (out_v),
    .clr_sticky (clr_sticky),
    .sticky_of  (sticky_of),
    .of_count   (of_count),
    .count      (count)
  );

  // Clock: 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge and settle 1 unit past it before sampling/driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] y, input logic of, input logic [2:0] f);
    in_valid = v;
    in_y     = y;
    in_of    = of;
    in_f     = f;
  endtask

  initial begin
    reset_n    = 1'b0;
    out_ready  = 1'b0;
    clr_sticky = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 3'd0);

    // Reset state
    #3;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_count",     {29'd0, count},     32'd0);
    chk("rst_sticky",    {31'd0, sticky_of}, 32'd0);
    chk("rst_of_count",  {24'd0, of_count},  32'd0);
    chk("rst_out_y",     out_y,              32'd0);
    step();
    reset_n = 1'b1;

    // Add with overflow, negative result; accepted on first edge after release
    drive(1'b1, 32'hFFFF_FFFE, 1'b1, 3'd2);
    step();
    drive(1'b0, 32'd0, 1'b0, 3'd0);
    chk("add_out_valid", {31'd0, out_valid}, 32'd1);
    chk("add_out_y",     out_y,              32'hFFFF_FFFE);
    chk("add_out_f",     {29'd0, out_f},     32'd2);
    chk("add_out_n",     {31'd0, out_n},     32'd1);
    chk("add_out_v",     {31'd0, out_v},     32'd1);
    chk("add_out_z",     {31'd0, out_z},     32'd0);
    chk("add_sticky",    {31'd0, sticky_of}, 32'd1);
    chk("add_of_count",  {24'd0, of_count},  32'd1);
    chk("add_count",     {29'd0, count},     32'd1);
    out_ready = 1'b1;
    step();
    chk("drain1_valid",  {31'd0, out_valid}, 32'd0);

    // Sub results: zero then nonzero, streamed with out_ready=1
    drive(1'b1, 32'd0, 1'b0, 3'd6);
    step();
    chk("sub0_z",        {31'd0, out_z},     32'd1);
    chk("sub0_v",        {31'd0, out_v},     32'd0);
    drive(1'b1, 32'h0000_00F0, 1'b0, 3'd6);
    step();
    drive(1'b0, 32'd0, 1'b0, 3'd0);
    chk("subf0_y",       out_y,              32'h0000_00F0);
    chk("subf0_z",       {31'd0, out_z},     32'd0);
    chk("subf0_n",       {31'd0, out_n},     32'd0);
    chk("subf0_v",       {31'd0, out_v},     32'd0);
    chk("subf0_count",   {29'd0, count},     32'd1);
    chk("subf0_sticky",  {31'd0, sticky_of}, 32'd1);
    step();
    chk("drain2_valid",  {31'd0, out_valid}, 32'd0);

    // Pop on empty does nothing
    step();
    chk("empty_pop_cnt", {29'd0, count},     32'd0);

    // Fill to full with out_ready=0; 5th push dropped
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 32'(i), 1'b0, 3'd0);
      chk($sformatf("fill_in_ready_%0d", i), {31'd0, in_ready}, (i <= 4) ? 32'd1 : 32'd0);
      step();
    end
    chk("full_count",    {29'd0, count},     32'd4);
    chk("full_in_ready", {31'd0, in_ready},  32'd0);
    // Full with out_ready=1 and a push offered: pop only, push refused
    out_ready = 1'b1;
    drive(1'b1, 32'd99, 1'b0, 3'd0);
    chk("full_pop_rdy",  {31'd0, in_ready},  32'd0);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("drain_y_%0d", i), out_y, 32'(i));
      step();
      drive(1'b0, 32'd0, 1'b0, 3'd0);
      if (i == 1) begin
        chk("after_full_rdy", {31'd0, in_ready}, 32'd1);
        chk("after_full_cnt", {29'd0, count},    32'd3);
      end
    end
    chk("drain3_valid",  {31'd0, out_valid}, 32'd0);

    // Simultaneous push/pop at count=2 preserves order and count
    out_ready = 1'b0;
    drive(1'b1, 32'd10, 1'b0, 3'd0);
    step();
    drive(1'b1, 32'd11, 1'b0, 3'd0);
    step();
    chk("pp_count_pre",  {29'd0, count},     32'd2);
    out_ready = 1'b1;
    drive(1'b1, 32'd12, 1'b0, 3'd0);
    step();
    chk("pp_count",      {29'd0, count},     32'd2);
    chk("pp_head",       out_y,              32'd11);
    out_ready = 1'b0;
    drive(1'b1, 32'd5, 1'b1, 3'd3);
    step();
    drive(1'b0, 32'd0, 1'b0, 3'd0);
    chk("f3_count",      {29'd0, count},     32'd3);
    chk("f3_of_count",   {24'd0, of_count},  32'd1);
    out_ready = 1'b1;
    step();
    chk("pp_order_12",   out_y,              32'd12);
    step();
    chk("f3_y",          out_y,              32'd5);
    chk("f3_f",          {29'd0, out_f},     32'd3);
    chk("f3_v",          {31'd0, out_v},     32'd0);
    step();
    chk("drain4_valid",  {31'd0, out_valid}, 32'd0);

    // Saturating overflow counter: 260 overflowing adds (starts at 1)
    for (int i = 1; i <= 260; i++) begin
      drive(1'b1, 32'(i), 1'b1, 3'd2);
      step();
      if (i == 100) chk("ofc_mid", {24'd0, of_count}, 32'd101);
    end
    chk("ofc_sat",       {24'd0, of_count},  32'd255);
    clr_sticky = 1'b1;
    step();
    chk("clr_vs_set",    {31'd0, sticky_of}, 32'd1);
    drive(1'b0, 32'd0, 1'b0, 3'd0);
    step();
    clr_sticky = 1'b0;
    chk("clr_alone",     {31'd0, sticky_of}, 32'd0);
    chk("clr_ofc_kept",  {24'd0, of_count},  32'd255);
    chk("clr_count",     {29'd0, count},     32'd0);

    // Asynchronous reset mid-operation with three entries buffered
    out_ready = 1'b0;
    for (int i = 7; i <= 9; i++) begin
      drive(1'b1, 32'(i), 1'b0, 3'd0);
      step();
    end
    drive(1'b0, 32'd0, 1'b0, 3'd0);
    chk("pre_rst_count", {29'd0, count},     32'd3);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_valid",    {31'd0, out_valid}, 32'd0);
    chk("arst_count",    {29'd0, count},     32'd0);
    chk("arst_of_count", {24'd0, of_count},  32'd0);
    chk("arst_in_ready", {31'd0, in_ready},  32'd1);
    chk("arst_out_y",    out_y,              32'd0);
    step();
    chk("arst_hold_cnt", {29'd0, count},     32'd0);
    reset_n = 1'b1;
    drive(1'b1, 32'h42, 1'b0, 3'd1);
    step();
    drive(1'b0, 32'd0, 1'b0, 3'd0);
    chk("post_rst_valid", {31'd0, out_valid}, 32'd1);
    chk("post_rst_y",     out_y,              32'h42);
    chk("post_rst_count", {29'd0, count},     32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit so the bench always ends.
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Sits directly downstream of the 32-bit ALU. Captures Y/OF/F, derives flags, buffers results in a FIFO, and tracks overflow history.

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the data width of the ALU result.
REQ-002 SHALL have parameter DEPTH, default 4, meaning the number of FIFO entries (power of two, at least 2).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1 bit: the ALU result on in_* is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the stage can accept an entry.
REQ-007 SHALL have port in_y, input, WIDTH bits: ALU result Y.
REQ-008 SHALL have port in_of, input, 1 bit: ALU overflow OF.
REQ-009 SHALL have port in_f, input, 3 bits: ALU function code F.
REQ-010 SHALL have port out_valid, output, 1 bit: the head entry is valid.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer accepts the head entry.
REQ-012 SHALL have port out_y, output, WIDTH bits: head result.
REQ-013 SHALL have port out_f, output, 3 bits: head function code.
REQ-014 SHALL have port out_z, output, 1 bit: head zero flag.
REQ-015 SHALL have port out_n, output, 1 bit: head negative flag.
REQ-016 SHALL have port out_v, output, 1 bit: head overflow flag.
REQ-017 SHALL have port clr_sticky, input, 1 bit: synchronous clear of sticky_of.
REQ-018 SHALL have port sticky_of, output, 1 bit: an overflow was pushed since the last clear or reset.
REQ-019 SHALL have port of_count, output, 8 bits: saturating count of pushed overflow entries.
REQ-020 SHALL have port count, output, $clog2(DEPTH+1) bits: current FIFO occupancy.

Function
REQ-021 SHALL define push = in_valid && in_ready.
REQ-022 SHALL define pop = out_valid && out_ready.
REQ-023 SHALL drive in_ready = (count < DEPTH), derived from registered state only, with no combinational path from out_ready.
REQ-024 SHALL drive out_valid = (count != 0).
REQ-025 SHALL drive out_* from the head entry, which stays stable while out_valid=1 and out_ready=0.
REQ-026 SHALL compute the flags at push time and store them with the entry: z = (in_y == 0), n = in_y[WIDTH-1], v = in_of if in_f is 3'd2 (add) or 3'd6 (sub), else 0.
REQ-027 SHALL accept and pass through other in_f codes unchanged, with v forced to 0 for them.
REQ-028 SHALL have 1-cycle latency: an entry pushed at edge k into an empty FIFO appears on out_* with out_valid=1 after edge k.
REQ-029 SHALL preserve strict FIFO order.
REQ-030 SHALL wrap the read and write pointers modulo DEPTH.
REQ-031 SHALL ignore in_* when in_valid=1 and full: no state change, and the entry is dropped at the source's responsibility.
REQ-032 SHALL not pop when out_ready=1 and empty; count stays 0.
REQ-033 SHALL, on simultaneous push and pop (not full, not empty), keep count unchanged, remove the head and append the new entry.
REQ-034 SHALL, when full with out_ready=1, pop the head while in_ready=0 that cycle; in_ready=1 on the next cycle.
REQ-035 SHALL set sticky_of on the edge where a pushed entry has v=1.
REQ-036 SHALL clear sticky_of on clr_sticky; when clr_sticky coincides with a v=1 push, the set wins and sticky_of=1.
REQ-037 SHALL increment of_count on each pushed v=1 entry, saturating at 255.
REQ-038 SHALL leave of_count unaffected by clr_sticky.

Reset
REQ-039 SHALL, while reset_n=0, immediately force count=0, pointers=0, out_valid=0, in_ready=1, sticky_of=0 and of_count=0; out_y, out_f, out_z, out_n and out_v SHALL read 0.
REQ-040 SHALL, on reset asserted mid-operation, discard all buffered entries; no partial pop or push completes on that edge.
REQ-041 SHALL accept a push on the first rising edge after reset_n deasserts.

Verification
REQ-042 SHALL be verified with: push Y=32'hFFFFFFFE, OF=1, F=2 -> next cycle out_valid=1, out_n=1, out_v=1, out_z=0, sticky_of=1, of_count=1, count=1.
REQ-043 SHALL be verified with: push Y=0, OF=0, F=6 then Y=32'h000000F0, OF=0, F=6, with out_ready=1 -> outputs in order z=1 then z=0, n=0, v=0, sticky_of unchanged.
REQ-044 SHALL be verified with: out_ready=0, push 5 entries with Y=1..5 -> in_ready=0 after the 4th, the 5th dropped, count=4; then out_ready=1 -> Y drains 1,2,3,4, then out_valid=0.
REQ-045 SHALL be verified with: count=2, push and pop in the same cycle -> count stays 2 and the order is preserved; push Y=5, OF=1, F=3 -> out_v=0, of_count unchanged.
REQ-046 SHALL be verified with: 260 pushes of OF=1, F=2 -> of_count=255; clr_sticky together with a v=1 push -> sticky_of=1; clr_sticky alone -> sticky_of=0 and of_count=255.
REQ-047 SHALL be verified with: count=3, assert reset_n=0 between edges -> out_valid=0, count=0 and of_count=0 immediately; after release, the first push appears one cycle later.
